// File: rtl/alu_pkg.sv
// Shared ALU issue definitions: operation codes, major opcodes
// and the skid-buffer occupancy states.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_XOR = 4'b0001;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_SRA = 4'b0111;
  localparam logic [3:0] ALU_EQ  = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_LUI = 4'b1010;
  localparam logic [3:0] ALU_SRL = 4'b1100;
  localparam logic [3:0] ALU_SLT = 4'b1110;
  localparam logic [3:0] ALU_ILL = 4'b1111;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  typedef enum logic [1:0] {
    BUF_EMPTY,
    BUF_ONE,
    BUF_TWO
  } buf_state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational mapping of decoded instruction fields to the
// ALU operation code and operands.
module alu_op_decode
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic [6:0]               opcode,
  input  logic [2:0]               funct3,
  input  logic [6:0]               funct7,
  input  logic [DATA_WIDTH-1:0]    rs1_data,
  input  logic [DATA_WIDTH-1:0]    rs2_data,
  input  logic [DATA_WIDTH-1:0]    imm,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic                     illegal
);

  logic [DATA_WIDTH-1:0] rs2_sh;
  logic [DATA_WIDTH-1:0] rs2_sra;
  logic [DATA_WIDTH-1:0] imm_sh;
  logic [DATA_WIDTH-1:0] imm_sra;
  logic [DATA_WIDTH-1:0] sra_flag;

  logic [3:0]            op;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic                  bad;

  // The ALU recognises arithmetic shifts by bit 10 of SrcB.
  assign sra_flag = {{(DATA_WIDTH-11){1'b0}}, 11'h400};
  assign rs2_sh   = {{(DATA_WIDTH-5){1'b0}}, rs2_data[4:0]};
  assign rs2_sra  = rs2_sh | sra_flag;
  assign imm_sh   = {{(DATA_WIDTH-5){1'b0}}, imm[4:0]};
  assign imm_sra  = {{(DATA_WIDTH-11){1'b0}}, imm[10:0]};

  always_comb begin
    op  = ALU_ADD;
    a   = rs1_data;
    b   = rs2_data;
    bad = 1'b0;
    case (opcode)
      OPC_R: begin
        case (funct3)
          3'b000: begin
            if (funct7 == F7_BASE) begin
              op = ALU_ADD;
            end else if (funct7 == F7_ALT) begin
              op = ALU_SUB;
            end else begin
              bad = 1'b1;
            end
          end
          3'b111: op = ALU_AND;
          3'b110: op = ALU_OR;
          3'b100: op = ALU_XOR;
          3'b010: op = ALU_SLT;
          3'b001: begin
            op = ALU_SLL;
            b  = rs2_sh;
          end
          3'b101: begin
            if (funct7 == F7_BASE) begin
              op = ALU_SRL;
              b  = rs2_sh;
            end else if (funct7 == F7_ALT) begin
              op = ALU_SRA;
              b  = rs2_sra;
            end else begin
              bad = 1'b1;
            end
          end
          default: bad = 1'b1;
        endcase
      end
      OPC_I: begin
        b = imm;
        case (funct3)
          3'b000: op = ALU_ADD;
          3'b010: op = ALU_SLT;
          3'b100: op = ALU_XOR;
          3'b110: op = ALU_OR;
          3'b111: op = ALU_AND;
          3'b001: begin
            op = ALU_SLL;
            b  = imm_sh;
          end
          3'b101: begin
            if (imm[10]) begin
              op = ALU_SRA;
              b  = imm_sra;
            end else begin
              op = ALU_SRL;
              b  = imm_sh;
            end
          end
          default: bad = 1'b1;
        endcase
      end
      OPC_LOAD, OPC_STORE, OPC_JALR: begin
        op = ALU_ADD;
        b  = imm;
      end
      OPC_BRANCH: begin
        case (funct3)
          3'b000, 3'b001: op = ALU_EQ;
          3'b100:         op = ALU_SLT;
          default:        bad = 1'b1;
        endcase
      end
      OPC_LUI: begin
        op = ALU_LUI;
        a  = '0;
        b  = imm;
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      op = ALU_ILL;
      a  = '0;
      b  = '0;
    end
  end

  assign Operation = op;
  assign SrcA      = a;
  assign SrcB      = b;
  assign illegal   = bad;

endmodule

// File: rtl/alu_issue.sv
// Issue register into execute: decodes ALU operands and holds
// them in a main register backed by a one-entry skid buffer.
module alu_issue
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [6:0]               opcode,
  input  logic [2:0]               funct3,
  input  logic [6:0]               funct7,
  input  logic [DATA_WIDTH-1:0]    rs1_data,
  input  logic [DATA_WIDTH-1:0]    rs2_data,
  input  logic [DATA_WIDTH-1:0]    imm,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     illegal
);

  logic [OPCODE_LENGTH-1:0] dec_op;
  logic [DATA_WIDTH-1:0]    dec_a;
  logic [DATA_WIDTH-1:0]    dec_b;
  logic                     dec_ill;

  alu_op_decode #(
    .DATA_WIDTH   (DATA_WIDTH),
    .OPCODE_LENGTH(OPCODE_LENGTH)
  ) u_dec (
    .opcode   (opcode),
    .funct3   (funct3),
    .funct7   (funct7),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .imm      (imm),
    .Operation(dec_op),
    .SrcA     (dec_a),
    .SrcB     (dec_b),
    .illegal  (dec_ill)
  );

  buf_state_t               state_q;
  logic                     in_ready_q;
  logic [OPCODE_LENGTH-1:0] main_op_q;
  logic [DATA_WIDTH-1:0]    main_a_q;
  logic [DATA_WIDTH-1:0]    main_b_q;
  logic                     main_ill_q;
  logic [OPCODE_LENGTH-1:0] skid_op_q;
  logic [DATA_WIDTH-1:0]    skid_a_q;
  logic [DATA_WIDTH-1:0]    skid_b_q;
  logic                     skid_ill_q;

  logic accept;
  logic consume;

  assign accept  = in_valid & in_ready_q;
  assign consume = (state_q != BUF_EMPTY) & out_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= BUF_EMPTY;
      in_ready_q <= 1'b1;
      main_op_q  <= '0;
      main_a_q   <= '0;
      main_b_q   <= '0;
      main_ill_q <= 1'b0;
      skid_op_q  <= '0;
      skid_a_q   <= '0;
      skid_b_q   <= '0;
      skid_ill_q <= 1'b0;
    end else if (flush) begin
      state_q    <= BUF_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      case (state_q)
        BUF_EMPTY: begin
          if (accept) begin
            main_op_q  <= dec_op;
            main_a_q   <= dec_a;
            main_b_q   <= dec_b;
            main_ill_q <= dec_ill;
            state_q    <= BUF_ONE;
          end
        end
        BUF_ONE: begin
          if (accept && consume) begin
            main_op_q  <= dec_op;
            main_a_q   <= dec_a;
            main_b_q   <= dec_b;
            main_ill_q <= dec_ill;
          end else if (accept) begin
            // Main is stalled; park the new entry in the skid slot.
            skid_op_q  <= dec_op;
            skid_a_q   <= dec_a;
            skid_b_q   <= dec_b;
            skid_ill_q <= dec_ill;
            state_q    <= BUF_TWO;
            in_ready_q <= 1'b0;
          end else if (consume) begin
            state_q <= BUF_EMPTY;
          end
        end
        BUF_TWO: begin
          if (consume) begin
            main_op_q  <= skid_op_q;
            main_a_q   <= skid_a_q;
            main_b_q   <= skid_b_q;
            main_ill_q <= skid_ill_q;
            state_q    <= BUF_ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= BUF_EMPTY;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != BUF_EMPTY);
  assign SrcA      = main_a_q;
  assign SrcB      = main_b_q;
  assign Operation = main_op_q;
  assign illegal   = main_ill_q;

endmodule
